pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
// - Parametrised, pipelined N-bit adder/subtractor. It supersedes the single-cycle 32-bit full adder.
// - Splits the carry chain into STAGES equal slices, with one register boundary per slice.
// - Uses a valid/ready handshake on both sides, so it can sit in a streaming datapath with back-pressure.
// - Adds subtract mode and signed-overflow detection.
// PARAMETERS
// - N       32  operand/result width in bits; N % STAGES must be 0.
// - STAGES  4   pipeline depth = latency in cycles; slice width W = N/STAGES. STAGES=1 gives a single registered adder.
// PORTS
// - clk        in   1  rising-edge clock.
// - rst        in   1  asynchronous, active-high reset.
// - in_valid   in   1  a/b/cin/sub are valid this cycle.
// - in_ready   out  1  block accepts the input this cycle (in_valid & in_ready = transfer).
// - a          in   N  operand A (unsigned or two's complement).
// - b          in   N  operand B.
// - cin        in   1  carry-in (add) / borrow-in (sub).
// - sub        in   1  0: s = a + b + cin; 1: s = a - b - cin.
// - out_valid  out  1  s/cout/ovf hold a result.
// - out_ready  in   1  downstream accepts the result (out_valid & out_ready = transfer).
// - s          out  N  result mod 2^N.
// - cout       out  1  carry-out. Sub mode: 1 = no borrow (a >= b+cin, unsigned).
// - ovf        out  1  signed overflow of the N-bit two's-complement operation.
// BEHAVIOUR
// - Arithmetic. Sub mode computes a + ~b + !cin, so sub=1,cin=0 gives a - b.
//   - ovf = carry into MSB XOR carry out of MSB.
// - Pipeline. Stage k (0..STAGES-1) adds slice k, bits [k*W +: W], of A and B' (B' = sub ? ~b : b).
//   - Carry-in of stage k is the registered carry of stage k-1; stage 0 uses cin^sub.
//   - Unprocessed upper operand slices are skewed forward through registers.
//   - Completed lower result slices are delayed so the full result emerges aligned.
// - Latency is exactly STAGES cycles from input transfer to out_valid, with no stall.
// - Throughput is 1 op/cycle while out_ready=1.
// - Flow control uses a single global enable:
//   - adv = !out_valid | out_ready; in_ready = adv.
//   - When adv=1, every stage register and its valid bit shift by one.
//   - Stage-0 valid loads in_valid, so bubbles propagate as invalid slots.
//   - When adv=0, all stages hold. s/cout/ovf must stay stable while out_valid & !out_ready.
// - in_ready is combinational from out_ready and out_valid. There is no path from in_valid to in_ready.
// - Reset: all valid bits cleared, and in-flight operations are discarded.
//   - Outputs during reset: out_valid=0, s=0, cout=0, ovf=0.
//   - in_ready=1 out of reset.
//   - Datapath registers reset to 0 so outputs are deterministic.
// - Reset asserted mid-stream: no partial result is ever presented. The first result after release belongs to the first input accepted after release.
// - Wrap-around: the result is mod 2^N. For example, all-ones + 1 gives s=0, cout=1.
// - Simultaneous out transfer and in transfer in the same cycle is legal and loses nothing.
// - Data and result ports are don't-care (no side effects) when the associated valid is low.
// STRUCTURE
// - Package pipe_addsub_pkg: default N/STAGES constants and a localparam helper for W.
//   - Elaboration check: N % STAGES != 0 -> $error.
// - One sub-module, addsub_slice: W-bit combinational ripple add.
//   - Inputs: a_s, b_s, ci. Outputs: s_s, co, and c_msb (carry into the slice MSB, used by the top slice for ovf).
// - Top level generates STAGES slice instances, the skew/deskew register triangles, the valid shift chain and adv.
// - The result is registered at the output (stage STAGES-1 output register).
// TESTING (N=32, STAGES=4 unless noted)
// - Add basic: a=0x0000_0005, b=0x0000_0003, cin=0, sub=0 -> after 4 cycles s=0x0000_0008, cout=0, ovf=0.
// - Carry ripple across all slices: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> s=0x0000_0000, cout=1, ovf=0.
// - Subtract / overflow:
//   - a=0x8000_0000, b=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, cout=1, ovf=1.
//   - a=3, b=5, sub=1 -> s=0xFFFF_FFFE, cout=0, ovf=0.
// - Streaming + back-pressure: drive a=i, b=i for i=0..39 with in_valid held high; hold out_ready=0 for cycles 10..14.
//   - Expect s=2*i, in order, with none dropped or duplicated.
//   - Expect in_ready=0 exactly while out_valid & !out_ready.
//   - Expect s stable during the hold.
// - Bubbles: toggle in_valid every other cycle -> out_valid pattern equals the in_valid pattern delayed 4 cycles.
// - Reset mid-stream: assert rst for 1 cycle with 3 ops in flight.
//   - Expect out_valid=0 and s=0 immediately (async).
//   - No stale result after release; the next op's result arrives 4 cycles after its acceptance.
//   - Repeat the streaming test with STAGES=1 and with N=64, STAGES=8.
// - Checker: a reference model a ± b ± cin in 65-bit math compares every transferred result, including ovf.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
//   DEFAULT_N       default operand/result width
//   DEFAULT_STAGES  default pipeline depth (latency in cycles)
//   slice_width()   bits handled by each pipeline stage
package pipe_addsub_pkg;

  localparam int DEFAULT_N      = 32;
  localparam int DEFAULT_STAGES = 4;

  // Width of one carry-chain slice; callers guarantee n is a multiple of stages.
  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Valid/ready stream bundle for pipe_addsub.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, s, cout, ovf
//   master = producer of operands / consumer of results (testbench or upstream logic)
//   slave  = the adder/subtractor itself
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int N = DEFAULT_N
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );

endinterface

// File: rtl/addsub_slice.sv
// One W-bit combinational ripple-add slice of the pipelined adder.
//   a_s, b_s  slice operands (b_s already inverted for subtract)
//   ci        carry into the slice LSB
//   s_s       slice sum
//   co        carry out of the slice MSB
//   c_msb     carry into the slice MSB (top slice uses it for signed overflow)
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic         ci,
  output logic [W-1:0] s_s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] sum;

  assign sum   = {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, ci};
  assign s_s   = sum[W-1:0];
  assign co    = sum[W];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum.
  assign c_msb = sum[W-1] ^ a_s[W-1] ^ b_s[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor with valid/ready flow control.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears every valid bit and datapath register
//   bus  pipe_addsub_if slave: operands a/b/cin/sub in, result s/cout/ovf out
// The carry chain is cut into STAGES slices of W = N/STAGES bits. Stage k adds
// slice k and registers it together with the finished lower slices (deskew) and
// the still-unprocessed upper operand slices (skew). A single enable, adv, moves
// the whole pipe, so a stalled output freezes every stage.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic          clk,
  input logic          rst,
  pipe_addsub_if.slave bus
);

  localparam int W = slice_width(N, STAGES);

  if (N % STAGES != 0) begin : g_bad_cfg
    $error("pipe_addsub: N must be a multiple of STAGES");
  end

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c_first;

  // Subtract is a + ~b + !cin, so invert b and the carry once at the entry.
  assign b_eff   = bus.b ^ {N{bus.sub}};
  assign c_first = bus.cin ^ bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE_W = (k + 1) * W;  // result bits finished once this stage registers
    localparam int REM_W  = N - DONE_W;   // operand bits still waiting for later stages

    logic [W-1:0]      sl_a;
    logic [W-1:0]      sl_b;
    logic [W-1:0]      sl_s;
    logic              sl_ci;
    logic              sl_co;
    logic              sl_cmsb;
    logic              vld_next;
    logic [DONE_W-1:0] res_next;
    logic              vld_r;
    logic [DONE_W-1:0] res_r;
    logic              c_r;

    if (k == 0) begin : g_src
      assign sl_a     = bus.a[W-1:0];
      assign sl_b     = b_eff[W-1:0];
      assign sl_ci    = c_first;
      assign vld_next = bus.in_valid;
      assign res_next = sl_s;
    end else begin : g_src
      assign sl_a     = g_stage[k-1].g_fwd.a_r[W-1:0];
      assign sl_b     = g_stage[k-1].g_fwd.b_r[W-1:0];
      assign sl_ci    = g_stage[k-1].c_r;
      assign vld_next = g_stage[k-1].vld_r;
      assign res_next = {sl_s, g_stage[k-1].res_r};
    end

    addsub_slice #(.W(W)) u_slice (
      .a_s   (sl_a),
      .b_s   (sl_b),
      .ci    (sl_ci),
      .s_s   (sl_s),
      .co    (sl_co),
      .c_msb (sl_cmsb)
    );

    // Stage register: valid bit, accumulated low result slices and slice carry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= 1'b0;
        res_r <= {DONE_W{1'b0}};
        c_r   <= 1'b0;
      end else if (adv) begin
        vld_r <= vld_next;
        res_r <= res_next;
        c_r   <= sl_co;
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic ovf_r;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= sl_cmsb ^ sl_co;
        end
      end
    end else begin : g_fwd
      logic [REM_W-1:0] a_next;
      logic [REM_W-1:0] b_next;
      logic [REM_W-1:0] a_r;
      logic [REM_W-1:0] b_r;
      logic             unused_cmsb;

      // Only the top slice needs its MSB carry.
      assign unused_cmsb = sl_cmsb;

      if (k == 0) begin : g_head
        assign a_next = bus.a[N-1:W];
        assign b_next = b_eff[N-1:W];
      end else begin : g_head
        assign a_next = g_stage[k-1].g_fwd.a_r[REM_W+W-1:W];
        assign b_next = g_stage[k-1].g_fwd.b_r[REM_W+W-1:W];
      end

      // Skew register: upper operand slices travel alongside their carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= {REM_W{1'b0}};
          b_r <= {REM_W{1'b0}};
        end else if (adv) begin
          a_r <= a_next;
          b_r <= b_next;
        end
      end
    end
  end

  // The pipe moves whenever the output slot is empty or being drained.
  assign adv           = !g_stage[STAGES-1].vld_r | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[STAGES-1].vld_r;
  assign bus.s         = g_stage[STAGES-1].res_r;
  assign bus.cout      = g_stage[STAGES-1].c_r;
  assign bus.ovf       = g_stage[STAGES-1].g_out.ovf_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: three instances (32/4, 32/1, 64/8) share
// one stimulus stream; a high-level arithmetic model feeds per-instance queues.
module tb_pipe_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_addsub_if #(.N(32)) bus_a ();
  pipe_addsub_if #(.N(32)) bus_b ();
  pipe_addsub_if #(.N(64)) bus_c ();

  pipe_addsub #(.N(32), .STAGES(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipe_addsub #(.N(32), .STAGES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  pipe_addsub #(.N(64), .STAGES(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  logic        drv_valid;
  logic [63:0] drv_a;
  logic [63:0] drv_b;
  logic        drv_cin;
  logic        drv_sub;
  logic        drv_oready;
  logic        all_ready;

  // Offer an operand only when all three instances can take it, so they see the same stream.
  assign all_ready = bus_a.in_ready & bus_b.in_ready & bus_c.in_ready;

  assign bus_a.in_valid = drv_valid & all_ready;
  assign bus_b.in_valid = drv_valid & all_ready;
  assign bus_c.in_valid = drv_valid & all_ready;
  assign bus_a.a = drv_a[31:0];
  assign bus_b.a = drv_a[31:0];
  assign bus_c.a = drv_a;
  assign bus_a.b = drv_b[31:0];
  assign bus_b.b = drv_b[31:0];
  assign bus_c.b = drv_b;
  assign bus_a.cin = drv_cin;
  assign bus_b.cin = drv_cin;
  assign bus_c.cin = drv_cin;
  assign bus_a.sub = drv_sub;
  assign bus_b.sub = drv_sub;
  assign bus_c.sub = drv_sub;
  assign bus_a.out_ready = drv_oready;
  assign bus_b.out_ready = drv_oready;
  assign bus_c.out_ready = drv_oready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [65:0] exp_q [3][$];
  logic        hold_f [3];
  logic [65:0] held_v [3];
  logic        vin_log [3][64];
  logic        vout_log [3][64];
  logic        log_en;
  int          log_idx;
  string       names [3] = '{"s4n32", "s1n32", "s8n64"};
  int          depth [3] = '{4, 1, 8};

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, result returned as {ovf, cout, s}.
  function automatic logic [65:0] ref_op(input int n, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
    logic signed [127:0] pow, half, ua, ub, sa, sb, ci, ur, sr;
    logic [63:0] mask;
    logic        cout, ovf;
    pow  = 128'sd1 <<< n;
    half = 128'sd1 <<< (n - 1);
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    ua = $signed({64'd0, a & mask});
    ub = $signed({64'd0, b & mask});
    sa = (ua >= half) ? ua - pow : ua;
    sb = (ub >= half) ? ub - pow : ub;
    ci = cin ? 128'sd1 : 128'sd0;
    if (sub) begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      cout = (ur >= 128'sd0);
    end else begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      cout = (ur >= pow);
    end
    ovf = (sr >= half) || (sr < -half);
    return {ovf, cout, ur[63:0] & mask};
  endfunction

  task automatic mon(input int id, input int n, input logic iv, input logic ir, input logic ov,
                     input logic ordy, input logic [63:0] s, input logic co, input logic of);
    logic [65:0] got;
    got = {of, co, s};
    if (ov) begin
      if (exp_q[id].size() == 0) check({names[id], "_stale_valid"}, {65'd0, ov}, 66'd0);
      else if (ordy) check({names[id], "_result"}, got, exp_q[id].pop_front());
    end
    check({names[id], "_in_ready"}, {65'd0, ir}, {65'd0, !(ov && !ordy)});
    if (hold_f[id]) begin
      check({names[id], "_hold_valid"}, {65'd0, ov}, 66'd1);
      check({names[id], "_hold_data"}, got, held_v[id]);
    end
    hold_f[id] = ov && !ordy;
    held_v[id] = got;
    if (iv && ir) exp_q[id].push_back(ref_op(n, drv_a, drv_b, drv_cin, drv_sub));
    if (log_en && log_idx < 64) begin
      vin_log[id][log_idx]  = iv && ir;
      vout_log[id][log_idx] = ov;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, 32, bus_a.in_valid, bus_a.in_ready, bus_a.out_valid, bus_a.out_ready,
          {32'd0, bus_a.s}, bus_a.cout, bus_a.ovf);
      mon(1, 32, bus_b.in_valid, bus_b.in_ready, bus_b.out_valid, bus_b.out_ready,
          {32'd0, bus_b.s}, bus_b.cout, bus_b.ovf);
      mon(2, 64, bus_c.in_valid, bus_c.in_ready, bus_c.out_valid, bus_c.out_ready,
          bus_c.s, bus_c.cout, bus_c.ovf);
      if (log_en) log_idx++;
    end
  end

  // Reset discards everything in flight.
  always @(posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      hold_f[i] = 1'b0;
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    logic acc;
    drv_a = a;
    drv_b = b;
    drv_cin = cin;
    drv_sub = sub;
    drv_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = bus_a.in_valid && bus_a.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", {65'd0, acc}, 66'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    drv_oready = 1'b1;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 66'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 66'd0);
  endtask

  // One isolated operation on the 32/4 instance with spec-given expected values.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        input logic [31:0] exp_s, input logic exp_cout, input logic exp_ovf);
    int   t0;
    logic got;
    drv_oready = 1'b1;
    @(posedge clk);
    #1;
    t0 = -1;
    drv_a = {32'd0, a};
    drv_b = {32'd0, b};
    drv_cin = cin;
    drv_sub = sub;
    drv_valid = 1'b1;
    for (int t = 0; t < 50 && t0 < 0; t++) begin
      @(negedge clk);
      if (bus_a.in_valid && bus_a.in_ready) t0 = cyc;
      @(posedge clk);
      #1;
    end
    drv_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        got = 1'b1;
        check("dir_latency", 66'(cyc - t0), 66'd4);
        check("dir_s", {34'd0, bus_a.s}, {34'd0, exp_s});
        check("dir_cout", {65'd0, bus_a.cout}, {65'd0, exp_cout});
        check("dir_ovf", {65'd0, bus_a.ovf}, {65'd0, exp_ovf});
      end
    end
    check("dir_timeout", {65'd0, got}, 66'd1);
  endtask

  task automatic rand_operand(output logic [63:0] v);
    case ($urandom_range(0, 4))
      0: v = 64'hFFFF_FFFF_FFFF_FFFF;
      1: v = 64'd0;
      2: v = {$urandom, 32'h8000_0000};
      3: v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom};
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        done;
    rst = 1'b1;
    drv_valid = 1'b0;
    drv_a = 64'd0;
    drv_b = 64'd0;
    drv_cin = 1'b0;
    drv_sub = 1'b0;
    drv_oready = 1'b1;
    log_en = 1'b0;
    log_idx = 0;
    #2;
    check("rst_out_valid", {65'd0, bus_a.out_valid}, 66'd0);
    check("rst_s", {34'd0, bus_a.s}, 66'd0);
    check("rst_cout", {65'd0, bus_a.cout}, 66'd0);
    check("rst_ovf", {65'd0, bus_a.ovf}, 66'd0);
    check("rst_in_ready", {65'd0, bus_a.in_ready}, 66'd1);
    check("rst_c_s", {2'd0, bus_c.s}, 66'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_drain();

    // Streaming with a 5-cycle output stall.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 40; i++) send(64'(i), 64'(i), 1'b0, 1'b0);
        drv_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          drv_oready = !(c >= 10 && c <= 14);
          @(posedge clk);
          #1;
        end
      end
    join
    wait_drain();

    // Random operands, modes and back-pressure.
    done = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          rand_operand(ra);
          rand_operand(rb);
          send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drv_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          drv_oready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        drv_oready = 1'b1;
      end
    join
    wait_drain();

    // Bubbles: out_valid must replay the accepted-input pattern after each latency.
    @(posedge clk);
    #1;
    log_idx = 0;
    log_en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      drv_valid = (c < 30) && (c % 2 == 0);
      drv_a = {$urandom, $urandom};
      drv_b = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    log_en = 1'b0;
    drv_valid = 1'b0;
    for (int id = 0; id < 3; id++)
      for (int t = depth[id]; t < 48; t++)
        check({names[id], "_bubble_valid"}, {65'd0, vout_log[id][t]}, {65'd0, vin_log[id][t - depth[id]]});
    wait_drain();

    // Reset with operations in flight.
    @(posedge clk);
    #1;
    for (int i = 1; i <= 6; i++) send(64'(i) * 64'h1111_1111, 64'(i), 1'b0, 1'b0);
    drv_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {65'd0, bus_a.out_valid}, 66'd0);
    check("mid_rst_s", {34'd0, bus_a.s}, 66'd0);
    check("mid_rst_cout", {65'd0, bus_a.cout}, 66'd0);
    check("mid_rst_ovf", {65'd0, bus_a.ovf}, 66'd0);
    check("mid_rst_in_ready", {65'd0, bus_a.in_ready}, 66'd1);
    check("mid_rst_c_valid", {65'd0, bus_c.out_valid}, 66'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    run_op(32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
